ysyx_22040383_pipe_ctrl: RTL and testbench

Central hazard and sequencing controller for the five-stage pipeline. It decides every cycle whether PC, IF/ID and ID/EX advance, hold or take a bubble, and drives the `invalid` input of the ID/EX register. It covers four cases: post-reset pipeline scrub, load-use interlock, EX-stage redirect flush, and data-memory wait freeze. It also keeps saturating stall and flush performance counters.

---
 rtl/ysyx_22040383_pipe_ctrl_pkg.sv | 16 +
 rtl/ysyx_22040383_sat_cnt.sv | 24 ++
 rtl/ysyx_22040383_pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_ysyx_22040383_pipe_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040383_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the load wb_select code used upstream to derive ex_is_load, and counter widths.
package ysyx_22040383_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ysyx_22040383_PC_BOOT     = 2'd0,
        ysyx_22040383_PC_RUN      = 2'd1,
        ysyx_22040383_PC_MEM_WAIT = 2'd2
    } pc_state_e;

    // wb_select value meaning "write back data returned by memory"
    localparam logic [1:0] WB_SEL_MEM = 2'd1;

    localparam int BOOT_CNT_W = 4;

endpackage

// File: rtl/ysyx_22040383_sat_cnt.sv
// Saturating event counter: +1 on each cycle with inc high, sticks at all-ones.
// Registered output, async active-high reset to zero.
module ysyx_22040383_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic w_at_max;

    assign w_at_max = &cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (inc && !w_at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_22040383_pipe_ctrl.sv
// Hazard/sequencing controller: post-reset scrub, load-use interlock, redirect flush
// and data-memory freeze. Control outputs are combinational (zero latency).
module ysyx_22040383_pipe_ctrl
    import ysyx_22040383_pipe_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_write_rf,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_invalid,
    output logic             idex_hold,
    output logic             exmem_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    pc_state_e             r_state;
    pc_state_e             w_state_nxt;
    logic [BOOT_CNT_W-1:0] r_boot_cnt;
    logic [BOOT_CNT_W-1:0] w_boot_cnt_nxt;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    // A load to x0 never produces a value, so it cannot create a hazard.
    assign w_rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    assign w_load_use = ex_is_load && ex_is_write_rf && (ex_rd != 5'd0)
                        && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= ysyx_22040383_PC_BOOT;
            r_boot_cnt <= BOOT_CNT_W'(BOOT_CYCLES);
        end else begin
            r_state    <= w_state_nxt;
            r_boot_cnt <= w_boot_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_boot_cnt_nxt = r_boot_cnt;
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idex_invalid   = 1'b0;
        idex_hold      = 1'b0;
        exmem_stall    = 1'b0;
        w_flush_inc    = 1'b0;

        case (r_state)
            ysyx_22040383_PC_BOOT: begin
                // ID/EX has no reset; keep injecting bubbles until it is clean.
                pc_stall     = 1'b1;
                ifid_flush   = 1'b1;
                idex_invalid = 1'b1;
                if (r_boot_cnt <= BOOT_CNT_W'(1)) begin
                    w_state_nxt = ysyx_22040383_PC_RUN;
                end else begin
                    w_boot_cnt_nxt = r_boot_cnt - BOOT_CNT_W'(1);
                end
            end

            ysyx_22040383_PC_RUN,
            ysyx_22040383_PC_MEM_WAIT: begin
                if (mem_busy) begin
                    // EX is frozen too, so a concurrent redirect re-presents later.
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_stall = 1'b1;
                    w_state_nxt = ysyx_22040383_PC_MEM_WAIT;
                end else begin
                    w_state_nxt = ysyx_22040383_PC_RUN;
                    if (ex_redirect) begin
                        ifid_flush   = 1'b1;
                        idex_invalid = 1'b1;
                        w_flush_inc  = 1'b1;
                    end else if (w_load_use) begin
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_invalid = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = ysyx_22040383_PC_BOOT;
            end
        endcase
    end

    assign w_stall_inc = pc_stall && (r_state != ysyx_22040383_PC_BOOT);

    ysyx_22040383_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .inc     (w_stall_inc),
        .cnt     (stall_cnt)
    );

    ysyx_22040383_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .inc     (w_flush_inc),
        .cnt     (flush_cnt)
    );

endmodule

// File: tb/tb_ysyx_22040383_pipe_ctrl.sv
// Bench for the pipeline hazard controller; a 32-bit and a 4-bit counter instance share stimulus.
module tb_ysyx_22040383_pipe_ctrl;

    localparam int BOOT = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_is_write_rf, ex_is_load, ex_redirect, mem_busy;

    logic        pc_stall, ifid_stall, ifid_flush, idex_invalid, idex_hold, exmem_stall;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc, s_ifs, s_iff, s_inv, s_hold, s_ex;
    logic [3:0]  stall_cnt4, flush_cnt4;

    ysyx_22040383_pipe_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(32)) u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_write_rf(ex_is_write_rf), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_invalid(idex_invalid), .idex_hold(idex_hold), .exmem_stall(exmem_stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ysyx_22040383_pipe_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(4)) u_dut4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_is_write_rf(ex_is_write_rf), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_stall(s_pc), .ifid_stall(s_ifs), .ifid_flush(s_iff),
        .idex_invalid(s_inv), .idex_hold(s_hold), .exmem_stall(s_ex),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    always #5 sys_clk = ~sys_clk;

    // {pc_stall, ifid_stall, ifid_flush, idex_invalid, idex_hold, exmem_stall}
    localparam logic [5:0] P_BOOT   = 6'b101100;
    localparam logic [5:0] P_FREEZE = 6'b110011;
    localparam logic [5:0] P_FLUSH  = 6'b001100;
    localparam logic [5:0] P_LDUSE  = 6'b110100;
    localparam logic [5:0] P_NONE   = 6'b000000;

    wire [5:0] ctl = {pc_stall, ifid_stall, ifid_flush, idex_invalid, idex_hold, exmem_stall};

    int     n_chk  = 0;
    int     n_pass = 0;
    int     boot_left;
    longint m_stall;
    longint m_flush;

    // Reference: what the pipeline must see this cycle, from the hazard rules alone.
    function automatic logic [5:0] exp_ctl();
        logic lu;
        if (sys_rst || boot_left > 0) return P_BOOT;
        if (mem_busy) return P_FREEZE;
        if (ex_redirect) return P_FLUSH;
        lu = ex_is_load && ex_is_write_rf && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        return lu ? P_LDUSE : P_NONE;
    endfunction

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic adv();
        logic [5:0] e;
        e = exp_ctl();
        if (boot_left > 0) boot_left--;
        else begin
            if (e[5]) m_stall++;
            if (e == P_FLUSH) m_flush++;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_is_write_rf = 0; ex_is_load = 0;
        ex_redirect = 0; mem_busy = 0;
    endtask

    task automatic rand_in(input int busy_pct, input int redir_pct);
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        ex_rd  = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom_range(0, 1));
        id_use_rs2 = 1'($urandom_range(0, 1));
        ex_is_write_rf = ($urandom_range(0, 9) < 8);
        ex_is_load     = ($urandom_range(0, 9) < 5);
        ex_redirect    = ($urandom_range(0, 99) < redir_pct);
        mem_busy       = ($urandom_range(0, 99) < busy_pct);
    endtask

    task automatic release_reset();
        @(posedge sys_clk);
        #1;
        sys_rst   = 1'b0;
        boot_left = BOOT;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        rand_in(50, 50);
        #3;
        n_chk++;
        if (ctl !== P_BOOT) $display("FAIL reset_ctl: got %b expected %b", ctl, P_BOOT);
        else n_pass++;
        n_chk++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
            $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        release_reset();
    endtask

    task automatic test_boot();
        for (int i = 0; i < BOOT + 2; i++) begin
            if (i < BOOT) rand_in(50, 50);
            else idle();
            #3;
            n_chk++;
            if (idex_invalid !== (i < BOOT) || ctl !== exp_ctl())
                $display("FAIL boot_cycle%0d: got %b expected %b", i, ctl, exp_ctl());
            else n_pass++;
            adv();
        end
        n_chk++;
        if (stall_cnt !== 32'd0) $display("FAIL boot_stall_cnt: got %0d expected 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_load_use();
        idle();
        ex_is_load = 1; ex_is_write_rf = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5; id_rs1 = 7;
        #3;
        n_chk++;
        if (ctl !== P_LDUSE) $display("FAIL load_use: got %b expected %b", ctl, P_LDUSE);
        else n_pass++;
        adv();
        idle();
        #3;
        n_chk++;
        if (ctl !== P_NONE || stall_cnt !== 32'(m_stall) || m_stall != 1)
            $display("FAIL load_use_after: got ctl=%b cnt=%0d expected ctl=%b cnt=1", ctl, stall_cnt, P_NONE);
        else n_pass++;
        adv();
        ex_is_load = 1; ex_is_write_rf = 1; ex_rd = 0; id_use_rs2 = 1; id_rs2 = 0;
        #3;
        n_chk++;
        if (ctl !== P_NONE) $display("FAIL load_use_x0: got %b expected %b", ctl, P_NONE);
        else n_pass++;
        adv();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i % 2 == 0) begin
                ex_is_load = 1; ex_is_write_rf = 1; ex_rd = 5'(3 + i);
                id_use_rs1 = 1; id_rs1 = 5'(3 + i);
            end
            #3;
            n_chk++;
            if (ctl !== ((i % 2 == 0) ? P_LDUSE : P_NONE))
                $display("FAIL b2b_cycle%0d: got %b expected %b", i, ctl, (i % 2 == 0) ? P_LDUSE : P_NONE);
            else n_pass++;
            adv();
        end
        n_chk++;
        if (stall_cnt !== 32'(m_stall)) $display("FAIL b2b_cnt: got %0d expected %0d", stall_cnt, m_stall);
        else n_pass++;
    endtask

    task automatic test_redirect();
        idle();
        ex_redirect = 1;
        ex_is_load = 1; ex_is_write_rf = 1; ex_rd = 9; id_use_rs1 = 1; id_rs1 = 9;
        #3;
        n_chk++;
        if (ctl !== P_FLUSH) $display("FAIL redirect: got %b expected %b", ctl, P_FLUSH);
        else n_pass++;
        adv();
        idle();
        #3;
        n_chk++;
        if (flush_cnt !== 32'(m_flush) || m_flush != 1)
            $display("FAIL redirect_cnt: got %0d expected 1", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        longint s0, f0;
        s0 = m_stall; f0 = m_flush;
        for (int i = 0; i < 4; i++) begin
            idle();
            ex_redirect = 1;
            mem_busy    = (i < 3);
            #3;
            n_chk++;
            if (ctl !== ((i < 3) ? P_FREEZE : P_FLUSH))
                $display("FAIL mem_wait_cycle%0d: got %b expected %b", i, ctl, (i < 3) ? P_FREEZE : P_FLUSH);
            else n_pass++;
            adv();
        end
        idle();
        #3;
        n_chk++;
        if (stall_cnt !== 32'(s0 + 3) || flush_cnt !== 32'(f0 + 1))
            $display("FAIL mem_wait_cnt: got stall=%0d flush=%0d expected %0d/%0d",
                     stall_cnt, flush_cnt, s0 + 3, f0 + 1);
        else n_pass++;
        // busy then release with a load-use pending: interlock applies on the release cycle
        mem_busy = 1;
        adv();
        mem_busy = 0; ex_is_load = 1; ex_is_write_rf = 1; ex_rd = 4; id_use_rs2 = 1; id_rs2 = 4;
        #3;
        n_chk++;
        if (ctl !== P_LDUSE) $display("FAIL mem_wait_exit_lu: got %b expected %b", ctl, P_LDUSE);
        else n_pass++;
        adv();
    endtask

    task automatic test_saturate();
        idle();
        mem_busy = 1;
        for (int i = 0; i < 20; i++) adv();
        idle();
        #3;
        n_chk++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 32'(m_stall))
            $display("FAIL saturate: got narrow=%0d wide=%0d expected 15/%0d", stall_cnt4, stall_cnt, m_stall);
        else n_pass++;
        adv();
    endtask

    task automatic test_reset_midwait();
        idle();
        mem_busy = 1;
        adv();
        #2;
        sys_rst = 1'b1;
        #1;
        n_chk++;
        if (ctl !== P_BOOT || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || stall_cnt4 !== 4'd0)
            $display("FAIL reset_midwait: got ctl=%b stall=%0d flush=%0d expected %b/0/0",
                     ctl, stall_cnt, flush_cnt, P_BOOT);
        else n_pass++;
        idle();
        release_reset();
        test_boot();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_in(20, 20);
            #3;
            n_chk++;
            if (ctl !== exp_ctl() || stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush) ||
                stall_cnt4 !== 4'(sat4(m_stall)) || flush_cnt4 !== 4'(sat4(m_flush)))
                $display("FAIL random_%0d: got ctl=%b s=%0d f=%0d s4=%0d f4=%0d expected ctl=%b s=%0d f=%0d",
                         i, ctl, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4, exp_ctl(), m_stall, m_flush);
            else n_pass++;
            adv();
        end
    endtask

    initial begin
        boot_left = BOOT;
        m_stall   = 0;
        m_flush   = 0;
        idle();
        test_reset();
        test_boot();
        test_load_use();
        test_back_to_back();
        test_redirect();
        test_mem_wait();
        test_saturate();
        test_reset_midwait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
